// File: rtl/tour_pkg.sv
// Shared constants and state type for the knight-tour command sequencer.
// Imported by knight_move_decode and tour_cmd_seq.
package tour_pkg;

    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_MOVE_FF = 4'h3;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    localparam logic [7:0] RESP_DONE_DEF = 8'hA5;
    localparam logic [7:0] RESP_BUSY_DEF = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VERT,
        ST_HOLD_V,
        ST_HORZ,
        ST_HOLD_H
    } tour_state_t;

endpackage

// File: rtl/knight_move_decode.sv
// Combinational split of a one-hot knight move into a vertical-leg command
// and a horizontal-leg command.
module knight_move_decode
    import tour_pkg::*;
(
    input  logic [7:0]  move,
    output logic [15:0] vert_cmd,
    output logic [15:0] horz_cmd
);

    logic [2:0] sel;
    logic       hit;
    logic [3:0] v_sq;
    logic [3:0] h_sq;
    logic [7:0] v_hdg;
    logic [7:0] h_hdg;

    always_comb begin
        sel   = 3'd0;
        hit   = 1'b0;
        v_sq  = 4'd0;
        h_sq  = 4'd0;
        v_hdg = HDG_N;
        h_hdg = HDG_N;

        // Scan downward so the lowest set bit is the one that sticks.
        for (int i = 7; i >= 0; i--) begin
            if (move[i]) begin
                sel = i[2:0];
                hit = 1'b1;
            end
        end

        if (hit) begin
            case (sel)
                3'd0: begin v_sq = 4'd2; v_hdg = HDG_N; h_sq = 4'd1; h_hdg = HDG_E; end
                3'd1: begin v_sq = 4'd2; v_hdg = HDG_N; h_sq = 4'd1; h_hdg = HDG_W; end
                3'd2: begin v_sq = 4'd1; v_hdg = HDG_N; h_sq = 4'd2; h_hdg = HDG_W; end
                3'd3: begin v_sq = 4'd1; v_hdg = HDG_S; h_sq = 4'd2; h_hdg = HDG_W; end
                3'd4: begin v_sq = 4'd2; v_hdg = HDG_S; h_sq = 4'd1; h_hdg = HDG_W; end
                3'd5: begin v_sq = 4'd2; v_hdg = HDG_S; h_sq = 4'd1; h_hdg = HDG_E; end
                3'd6: begin v_sq = 4'd1; v_hdg = HDG_S; h_sq = 4'd2; h_hdg = HDG_E; end
                3'd7: begin v_sq = 4'd1; v_hdg = HDG_N; h_sq = 4'd2; h_hdg = HDG_E; end
            endcase
        end

        vert_cmd = {OP_MOVE, v_hdg, v_sq};
        horz_cmd = {OP_MOVE_FF, h_hdg, h_sq};
    end

endmodule

// File: rtl/tour_cmd_seq.sv
// Tour command sequencer: turns each knight move into vertical+horizontal legs
// and muxes them with UART commands onto the cmd_proc bus. Macro TOUR_ABORT_EN adds UART abort.
//
// state     | meaning
// ST_IDLE   | UART commands pass through to cmd_proc
// ST_VERT   | vertical leg offered, waiting for clr_cmd_rdy
// ST_HOLD_V | vertical leg executing, waiting for send_resp
// ST_HORZ   | horizontal leg offered, waiting for clr_cmd_rdy
// ST_HOLD_H | horizontal leg executing, waiting for send_resp
module tour_cmd_seq
    import tour_pkg::*;
#(
    parameter int          BOARD_DIM = 5,
    parameter int          IDX_W     = $clog2(BOARD_DIM * BOARD_DIM),
    parameter logic [7:0]  RESP_DONE = RESP_DONE_DEF,
    parameter logic [7:0]  RESP_BUSY = RESP_BUSY_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    input  logic             clr_cmd_rdy,
    output logic             clr_cmd_rdy_UART,
    input  logic             send_resp,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    output logic [7:0]       resp,
    output logic             tour_active
);

    localparam int               NUM_MOVES = BOARD_DIM * BOARD_DIM - 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_MOVES - 1);

    tour_state_t      state;
    tour_state_t      state_nxt;
    logic [IDX_W-1:0] mv_nxt;
    logic [15:0]      vert_cmd;
    logic [15:0]      horz_cmd;
    logic             abort_req;
    logic             last_move;

    knight_move_decode u_decode (
        .move     (move),
        .vert_cmd (vert_cmd),
        .horz_cmd (horz_cmd)
    );

`ifdef TOUR_ABORT_EN
    assign abort_req = cmd_rdy_UART & send_resp;
`else
    assign abort_req = 1'b0;
`endif

    assign last_move   = (mv_indx == LAST_IDX);
    assign tour_active = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            mv_indx <= '0;
        end else begin
            state   <= state_nxt;
            mv_indx <= mv_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        mv_nxt           = mv_indx;
        cmd              = vert_cmd;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = RESP_BUSY;

        case (state)
            ST_IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = RESP_DONE;
                if (start_tour) begin
                    state_nxt = ST_VERT;
                    mv_nxt    = '0;
                end
            end
            ST_VERT: begin
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) state_nxt = ST_HOLD_V;
            end
            ST_HOLD_V: begin
                if (abort_req) begin
                    resp      = RESP_DONE;
                    state_nxt = ST_IDLE;
                    mv_nxt    = '0;
                end else if (send_resp) begin
                    state_nxt = ST_HORZ;
                end
            end
            ST_HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) state_nxt = ST_HOLD_H;
            end
            ST_HOLD_H: begin
                cmd = horz_cmd;
                if (last_move) resp = RESP_DONE;
                if (abort_req) begin
                    resp      = RESP_DONE;
                    state_nxt = ST_IDLE;
                    mv_nxt    = '0;
                end else if (send_resp) begin
                    if (last_move) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        mv_nxt    = mv_indx + 1'b1;
                        state_nxt = ST_VERT;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: doc/tour_cmd_seq.md
Name: tour_cmd_seq

Overview:
- Parametrised tour command sequencer.
- Converts each one-hot knight move from the tour solver into two sequential movement commands: a vertical leg, then a horizontal leg.
- Multiplexes these tour commands with Bluetooth/UART commands onto the single command bus feeding cmd_proc.
- Generalised to any square board, with a UART-clear gate and an optional UART abort; it sits between UART_wrapper, TourLogic and cmd_proc.

Parameters:
BOARD_DIM, 5, board edge length in squares (3..8); tour length NUM_MOVES = BOARD_DIM*BOARD_DIM-1 (localparam)
IDX_W, $clog2(BOARD_DIM*BOARD_DIM), width of move index
RESP_DONE, 8'hA5, response byte when tour/command complete
RESP_BUSY, 8'h5A, response byte while tour in progress

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_tour  in  1  pulse: solver finished, tour moves valid
move  in  8  one-hot knight move at mv_indx
mv_indx  out  IDX_W  index of move being executed
cmd_UART  in  16  command from UART_wrapper
cmd_rdy_UART  in  1  UART command pending
clr_cmd_rdy  in  1  cmd_proc consumed cmd
clr_cmd_rdy_UART  out  1  clear to UART_wrapper
send_resp  in  1  cmd_proc finished current command
cmd  out  16  muxed command to cmd_proc
cmd_rdy  out  1  muxed command ready
resp  out  8  response byte to UART_wrapper
tour_active  out  1  high while not IDLE

Behaviour:
- One clock domain: clk. rst_n is asynchronous, active-low. Reset forces state IDLE, mv_indx=0 and all registered outputs to 0.
- Command format: cmd[15:12] opcode (4'h2 move, 4'h3 move+fanfare), cmd[11:4] heading (N 8'h00, W 8'h3F, S 8'h7F, E 8'hBF), cmd[3:0] squares.
- Move decode (bit: dx,dy): 0:+1,+2  1:-1,+2  2:-2,+1  3:-2,-1  4:-1,-2  5:+1,-2  6:+2,-1  7:+2,+1.
  - Vertical leg = |dy| squares, N if dy>0, else S, opcode 4'h2.
  - Horizontal leg = |dx| squares, E if dx>0, else W, opcode 4'h3.
  - Multi-hot move: lowest set bit wins.
  - All-zero move: both legs issued with squares=0, heading N, opcode unchanged.
- States:
  - IDLE: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy. start_tour -> VERT, mv_indx<=0.
  - VERT: cmd=vertical leg, cmd_rdy=1. clr_cmd_rdy -> HOLD_V.
  - HOLD_V: cmd_rdy=0. send_resp -> HORZ.
  - HORZ: cmd=horizontal leg, cmd_rdy=1. clr_cmd_rdy -> HOLD_H.
  - HOLD_H: send_resp -> IDLE if mv_indx==NUM_MOVES-1; else mv_indx+1, -> VERT.
- Outside IDLE, clr_cmd_rdy_UART=0: a UART command stays pending and is presented one cycle after return to IDLE.
- cmd, cmd_rdy and resp are combinational from state/mv_indx/move/cmd_UART, so cmd_rdy is visible in the same cycle as the transition into VERT/HORZ. move must be stable while its index is held.
- resp = RESP_DONE in IDLE, or in HOLD_H with mv_indx==NUM_MOVES-1; otherwise RESP_BUSY.
- start_tour outside IDLE: ignored.
- clr_cmd_rdy or send_resp in a state not listed above: ignored.
- mv_indx never exceeds NUM_MOVES-1; it does not wrap.
- rst_n asserted mid-tour: immediate return to IDLE; no further tour commands issued.

Optional Feature:
TOUR_ABORT_EN.
- Defined: cmd_rdy_UART=1 while in HOLD_V or HOLD_H, together with send_resp, sends the FSM to IDLE instead of advancing. mv_indx resets to 0, resp=RESP_DONE in that cycle, and the pending UART command is presented next cycle.
- Undefined: UART commands are held off for the whole tour, per the base behaviour.

Decomposition:
- Package tour_pkg: opcode constants (OP_MOVE, OP_MOVE_FF); heading constants (HDG_N/W/S/E); state enum typedef; RESP_DONE/RESP_BUSY defaults.
- One sub-module, knight_move_decode: combinational, move[7:0] -> {vert_cmd[15:0], horz_cmd[15:0]}.

Test Plan:
- UART passthrough: IDLE, cmd_UART=16'h2003 with cmd_rdy_UART=1 -> cmd=16'h2003, cmd_rdy=1; clr_cmd_rdy -> clr_cmd_rdy_UART=1 same cycle; resp=8'hA5.
- Single move decode: start_tour, move=8'h01.
  - VERT: cmd=16'h2002.
  - After clr + send_resp: cmd=16'h3BF1.
  - After next clr: mv_indx=0.
  - Next send_resp: mv_indx=1, resp=8'h5A at that send_resp.
- Full tour, BOARD_DIM=5: model responds to every cmd_rdy -> exactly 48 commands, mv_indx ends at 23, final send_resp sees resp=8'hA5, then IDLE.
- UART hold-off (macro undefined): cmd_rdy_UART asserted at move 3 -> no clr_cmd_rdy_UART during tour; cmd_UART presented after completion.
- Abort (TOUR_ABORT_EN): cmd_rdy_UART high in HOLD_V of move 5, then send_resp -> IDLE next cycle, mv_indx=0, resp=8'hA5 at abort.
- Reset mid-HORZ: rst_n low -> cmd_rdy=0, tour_active=0, mv_indx=0 asynchronously; start_tour held high during VERT is ignored.
